// File: rtl/addr_scan_seq.sv
// ============================================================================
// Module   : addr_scan_seq
// Purpose  : Programmable 4-bit address sequencer for the 4-to-16 decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_scan_seq #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic               dir_down,
   input  logic [3:0]         first,
   input  logic [3:0]         last,
   input  logic [DWELL_W-1:0] dwell,
   output logic [3:0]         addr,
   output logic               valid,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);
   localparam logic [DWELL_W-1:0] CNT_ZERO = '0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         addr_q, addr_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;

   logic [3:0]         cfg_first_q, cfg_first_d;
   logic [3:0]         cfg_last_q, cfg_last_d;
   logic               cfg_down_q, cfg_down_d;
   logic               cfg_cont_q, cfg_cont_d;
   logic [DWELL_W-1:0] cfg_dwell_q, cfg_dwell_d;

   logic [3:0]         step_addr;

   // 4-bit arithmetic gives the modulo-16 wrap through 15/0 for free
   assign step_addr = cfg_down_q ? (addr_q - 4'd1) : (addr_q + 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      wrap_d      = 1'b0;
      cnt_d       = cnt_q;
      cfg_first_d = cfg_first_q;
      cfg_last_d  = cfg_last_q;
      cfg_down_d  = cfg_down_q;
      cfg_cont_d  = cfg_cont_q;
      cfg_dwell_d = cfg_dwell_q;

      case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            if (start && !stop) begin
               state_d     = ST_SCAN;
               addr_d      = first;
               valid_d     = 1'b1;
               busy_d      = 1'b1;
               cnt_d       = dwell;
               cfg_first_d = first;
               cfg_last_d  = last;
               cfg_down_d  = dir_down;
               cfg_cont_d  = mode_cont;
               cfg_dwell_d = dwell;
            end
         end

         ST_SCAN: begin
            // Abort takes priority over any advance or end-of-pass this cycle
            if (stop) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (addr_q != cfg_last_q) begin
               addr_d = step_addr;
               cnt_d  = cfg_dwell_q;
            end else if (cfg_cont_q) begin
               addr_d = cfg_first_q;
               cnt_d  = cfg_dwell_q;
               wrap_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= 4'd0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         cnt_q       <= CNT_ZERO;
         cfg_first_q <= 4'd0;
         cfg_last_q  <= 4'd0;
         cfg_down_q  <= 1'b0;
         cfg_cont_q  <= 1'b0;
         cfg_dwell_q <= CNT_ZERO;
      end else begin
         addr_q      <= addr_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wrap_q      <= wrap_d;
         cnt_q       <= cnt_d;
         cfg_first_q <= cfg_first_d;
         cfg_last_q  <= cfg_last_d;
         cfg_down_q  <= cfg_down_d;
         cfg_cont_q  <= cfg_cont_d;
         cfg_dwell_q <= cfg_dwell_d;
      end
   end

   assign addr  = addr_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign wrap  = wrap_q;

endmodule

`default_nettype wire

// File: doc/addr_scan_seq.md
# addr_scan_seq

Programmable address sequencer that generates the 4-bit address stream feeding the 4-to-16 decoder stage. Once started, it steps ADDR through a configurable range, up or down, holding each address for a programmable dwell time. It runs either a single pass or continuously. VALID qualifies ADDR so the decoder's one-hot output can be gated downstream.

## Interface
Clock is CLK; reset is RST_N, asynchronous, active-low.

Parameters:
- DWELL_W, 8, width of the dwell count.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- START  input  1  start request; sampled only in IDLE.
- STOP  input  1  abort request; honoured in any state.
- MODE_CONT  input  1  1 = continuous passes, 0 = single pass.
- DIR_DOWN  input  1  1 = decrement, 0 = increment.
- FIRST  input  4  first address of the pass.
- LAST  input  4  last address of the pass.
- DWELL  input  DWELL_W  extra hold cycles per address; each address is held DWELL+1 cycles.
- ADDR  output  4  current address to the decoder.
- VALID  output  1  ADDR is an active scan address.
- BUSY  output  1  sequencer is not idle.
- DONE  output  1  one-cycle pulse at the end of a single pass.
- WRAP  output  1  one-cycle pulse when a continuous pass reloads FIRST.

## Operation
- States are IDLE and SCAN.
- Configuration is latched on the START edge in IDLE. The latched set is FIRST, LAST, DIR_DOWN, MODE_CONT and DWELL. Input changes during SCAN have no effect.
- IDLE → SCAN on START=1 and STOP=0. On that edge: ADDR←FIRST, VALID←1, BUSY←1, dwell counter←DWELL.
- In SCAN, the dwell counter decrements each cycle. When it reaches 0, the address advances:
  - If ADDR ≠ LAST: ADDR ← ADDR±1 modulo 16 (15+1→0, 0−1→15), and the counter reloads DWELL.
  - If ADDR = LAST and MODE_CONT=1: ADDR←FIRST, the counter reloads, and WRAP pulses for that one cycle.
  - If ADDR = LAST and MODE_CONT=0: SCAN → IDLE, with VALID←0, BUSY←0 and DONE pulsed for that one cycle.
- Pass length is N = ((LAST−FIRST) mod 16)+1 when counting up, and ((FIRST−LAST) mod 16)+1 when counting down.
  - FIRST=LAST gives N=1.
  - The range wraps through 15/0 when needed.
- STOP=1 in SCAN: next edge goes to IDLE with VALID=0 and BUSY=0. DONE and WRAP are not asserted. STOP beats any simultaneous advance or end of pass.
- START and STOP in the same cycle while in IDLE: STOP wins and the sequencer stays in IDLE.
- START while in SCAN is ignored.
- In IDLE, ADDR holds its last value. VALID=0, DONE=0 and WRAP=0, except that DONE is high in the first IDLE cycle after a completed single pass.
- Reset values: ADDR=0, VALID=0, BUSY=0, DONE=0, WRAP=0, state IDLE, dwell counter 0. Reset mid-scan aborts immediately with no DONE.

## Timing
- Start latency is 1 cycle: START is sampled at edge k, and ADDR=FIRST with VALID=1 is visible after edge k.
- Each address is valid for exactly DWELL+1 consecutive cycles. There are no gap cycles between addresses or between continuous passes.
- A single pass gives exactly N·(DWELL+1) VALID cycles. DONE coincides with the first cycle in which VALID=0.
- A new START is accepted in the same cycle that DONE is high, so back-to-back passes have a 1-cycle gap.
- WRAP is high during the first cycle of the reloaded FIRST address.
- All outputs are registered. No combinational path exists from any input to any output.

## Test plan
- Reset: assert RST_N=0 mid-scan, asynchronously between edges. Required: ADDR=0, VALID=0, BUSY=0, DONE=0 and WRAP=0 immediately. No output activity until the next START.
- Single up pass: FIRST=2, LAST=5, DWELL=1, MODE_CONT=0. Required: ADDR=2,2,3,3,4,4,5,5 with VALID=1 for 8 cycles, then DONE=1 for one cycle with VALID=0 and BUSY=0, and ADDR held at 5.
- Wrap-around up: FIRST=14, LAST=1, DWELL=0, single pass. Required: ADDR=14,15,0,1, then DONE; 4 VALID cycles total.
- Continuous down: FIRST=3, LAST=0, DWELL=0, MODE_CONT=1, run 10 cycles. Required: ADDR=3,2,1,0,3,2,1,0,3,2, with WRAP=1 only on cycles 5 and 9 (the reloaded 3s). DONE is never asserted.
- Control conflicts: START with STOP in IDLE → stays IDLE. START during SCAN → no restart. STOP during the 2nd cycle of DWELL=3 on address 7 → VALID=0 and BUSY=0 next cycle, DONE=0, ADDR held at 7.
- Back-to-back: FIRST=LAST=9, DWELL=0, single pass, with START re-asserted on the DONE cycle. Required: VALID pattern 1,0,1 with ADDR=9 throughout, and DONE pulsed twice.
